// File: rtl/pe_row_ws_dbuf.sv
// Weight-stationary systolic PE row with shadow/active weight buffers,
// a drain-before-swap sequencer, per-column sum valids and optional saturation.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | accepting activations; swap_req starts a drain
//   DRAIN | act_ready low; waiting for every in-flight valid to exit
//   SWAP  | one cycle; active weights already hold the shadow, swap_done high
module pe_row_ws_dbuf #(
   parameter int DATA_W = 24,
   parameter int COLS   = 13,
   parameter int ACC_W  = 48
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     act_valid_in,
   input  logic [DATA_W-1:0]        active_left,
   output logic                     act_ready,
   output logic [DATA_W-1:0]        active_right,
   output logic                     act_valid_out,
   input  logic                     w_load,
   input  logic [DATA_W*COLS-1:0]   in_weight_above,
   output logic [DATA_W*COLS-1:0]   out_weight_below,
   input  logic                     swap_req,
   output logic                     swap_done,
   input  logic                     sat_en,
   input  logic [ACC_W*COLS-1:0]    in_sum,
   output logic [ACC_W*COLS-1:0]    out_sum,
   output logic [COLS-1:0]          sum_valid,
   output logic                     err_drop
);

   typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;

   localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t            state;
   logic [DATA_W-1:0] act_r  [COLS];
   logic              vld_r  [COLS];
   logic [DATA_W-1:0] shadow [COLS];
   logic [DATA_W-1:0] act_w  [COLS];
   logic [DATA_W-1:0] a_c    [COLS];
   logic              v_c    [COLS];
   logic [ACC_W-1:0]  sum_nxt [COLS];
   logic              v_in;
   logic              pipe_empty;
   logic              swap_commit;

   assign v_in        = act_valid_in & act_ready;
   assign swap_commit = (state == DRAIN) && pipe_empty;

   always_comb begin
      pipe_empty = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         if (vld_r[c]) pipe_empty = 1'b0;
      end
   end

   always_comb begin
      a_c[0] = active_left;
      v_c[0] = v_in;
      for (int c = 1; c < COLS; c++) begin
         a_c[c] = act_r[c-1];
         v_c[c] = vld_r[c-1];
      end
   end

   // One extra headroom bit: overflow shows as disagreement of the top two bits.
   always_comb begin
      logic signed [2*DATA_W-1:0] prod;
      logic [ACC_W:0]             ext;
      prod = '0;
      ext  = '0;
      for (int c = 0; c < COLS; c++) begin
         prod = $signed(a_c[c]) * $signed(act_w[c]);
         ext  = {in_sum[c*ACC_W+ACC_W-1], in_sum[c*ACC_W +: ACC_W]}
              + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
         if (sat_en && (ext[ACC_W] != ext[ACC_W-1]))
            sum_nxt[c] = ext[ACC_W] ? SAT_MIN : SAT_MAX;
         else
            sum_nxt[c] = ext[ACC_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < COLS; c++) begin
            act_r[c]  <= '0;
            vld_r[c]  <= 1'b0;
            shadow[c] <= '0;
            act_w[c]  <= '0;
         end
         out_sum   <= '0;
         sum_valid <= '0;
      end else begin
         for (int c = 0; c < COLS; c++) begin
            act_r[c]                    <= a_c[c];
            vld_r[c]                    <= v_c[c];
            out_sum[c*ACC_W +: ACC_W]   <= sum_nxt[c];
            sum_valid[c]                <= v_c[c];
            if (w_load)      shadow[c]  <= in_weight_above[c*DATA_W +: DATA_W];
            if (swap_commit) act_w[c]   <= shadow[c];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         act_ready <= 1'b1;
         swap_done <= 1'b0;
         err_drop  <= 1'b0;
      end else begin
         swap_done <= 1'b0;
         if (act_valid_in && !act_ready) err_drop <= 1'b1;
         case (state)
            IDLE: begin
               if (swap_req) begin
                  state     <= DRAIN;
                  act_ready <= 1'b0;
               end
            end
            DRAIN: begin
               if (pipe_empty) begin
                  state     <= SWAP;
                  swap_done <= 1'b1;
               end
            end
            SWAP: begin
               state     <= IDLE;
               act_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               act_ready <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      out_weight_below = '0;
      for (int c = 0; c < COLS; c++) out_weight_below[c*DATA_W +: DATA_W] = shadow[c];
   end

   assign active_right  = act_r[COLS-1];
   assign act_valid_out = vld_r[COLS-1];

endmodule

// File: tb/tb_pe_row_ws_dbuf.sv
// Directed bench for pe_row_ws_dbuf: MAC/saturation vector table plus
// hand sequences for pass-through latency, swap drain, protocol error and reset.
module tb_pe_row_ws_dbuf;
   localparam int DATA_W = 24;
   localparam int COLS   = 13;
   localparam int ACC_W  = 48;

   localparam longint MAXW = 64'sd8388607;
   localparam longint MINW = -64'sd8388608;
   localparam longint MAXS = 64'sd140737488355327;
   localparam longint MINS = -64'sd140737488355328;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   act_valid_in = 1'b0;
   logic [DATA_W-1:0]      active_left = '0;
   logic                   act_ready;
   logic [DATA_W-1:0]      active_right;
   logic                   act_valid_out;
   logic                   w_load = 1'b0;
   logic [DATA_W*COLS-1:0] in_weight_above = '0;
   logic [DATA_W*COLS-1:0] out_weight_below;
   logic                   swap_req = 1'b0;
   logic                   swap_done;
   logic                   sat_en = 1'b0;
   logic [ACC_W*COLS-1:0]  in_sum = '0;
   logic [ACC_W*COLS-1:0]  out_sum;
   logic [COLS-1:0]        sum_valid;
   logic                   err_drop;

   int total = 0;
   int bad   = 0;

   pe_row_ws_dbuf #(.DATA_W(DATA_W), .COLS(COLS), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .act_valid_in(act_valid_in), .active_left(active_left), .act_ready(act_ready),
      .active_right(active_right), .act_valid_out(act_valid_out),
      .w_load(w_load), .in_weight_above(in_weight_above), .out_weight_below(out_weight_below),
      .swap_req(swap_req), .swap_done(swap_done), .sat_en(sat_en),
      .in_sum(in_sum), .out_sum(out_sum), .sum_valid(sum_valid), .err_drop(err_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint w;
      longint a;
      longint s;
      logic   sat;
      longint exp;
   } vec_t;

   vec_t tbl [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   function automatic longint sum_col(input int c);
      return longint'($signed(out_sum[c*ACC_W +: ACC_W]));
   endfunction

   function automatic longint wb_col(input int c);
      return longint'($signed(out_weight_below[c*DATA_W +: DATA_W]));
   endfunction

   task automatic set_act(input longint a);
      active_left = a[DATA_W-1:0];
   endtask

   task automatic set_weights(input longint w);
      for (int c = 0; c < COLS; c++) in_weight_above[c*DATA_W +: DATA_W] = w[DATA_W-1:0];
   endtask

   task automatic set_in_sum(input longint s);
      for (int c = 0; c < COLS; c++) in_sum[c*ACC_W +: ACC_W] = s[ACC_W-1:0];
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (swap_done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk("swap_done_seen", swap_done, 1);
   endtask

   task automatic load_and_swap(input longint w);
      set_weights(w);
      w_load = 1'b1;
      tick();
      w_load = 1'b0;
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      wait_done(2*COLS + 4);
      tick();
   endtask

   initial begin
      int seen;
      int done_cnt;

      tbl[0] = '{w: 3,    a: -4,   s: 10,   sat: 1'b1, exp: -2};
      tbl[1] = '{w: -7,   a: 100,  s: 0,    sat: 1'b0, exp: -700};
      tbl[2] = '{w: MAXW, a: MAXW, s: MAXS, sat: 1'b1, exp: MAXS};
      tbl[3] = '{w: MAXW, a: MAXW, s: MAXS, sat: 1'b0, exp: -64'sd70368760954880};
      tbl[4] = '{w: MINW, a: MAXW, s: MINS, sat: 1'b1, exp: MINS};
      tbl[5] = '{w: MINW, a: MAXW, s: MINS, sat: 1'b0, exp: 64'sd70368752566272};
      tbl[6] = '{w: MINW, a: MINW, s: MAXS, sat: 1'b1, exp: MAXS};
      tbl[7] = '{w: MINW, a: MINW, s: -5,   sat: 1'b0, exp: 64'sd70368744177659};

      // power-on reset
      tick();
      tick();
      chk("por_ready", act_ready, 1);
      chk("por_err", err_drop, 0);
      chk("por_sum_nz", |out_sum, 0);
      rst_n = 1'b1;
      tick();

      // pass-through latency
      set_act(5);
      act_valid_in = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (i == 1) begin
            act_valid_in = 1'b0;
            set_act(0);
         end
         chk("pt_valid", act_valid_out, (i == COLS) ? 1 : 0);
         if (i == COLS) chk("pt_data", active_right, 5);
      end

      // MAC ripple through all columns
      load_and_swap(3);
      set_in_sum(10);
      sat_en = 1'b1;
      set_act(-4);
      act_valid_in = 1'b1;
      for (int i = 1; i <= COLS + 1; i++) begin
         tick();
         if (i == 1) begin
            act_valid_in = 1'b0;
            set_act(0);
         end
         chk("mac_vld", sum_valid, (i <= COLS) ? (longint'(1) << (i-1)) : 0);
         if (i <= COLS) chk("mac_sum", sum_col(i-1), -2);
      end

      // vector table: arithmetic, saturation and wrap on column 0
      foreach (tbl[k]) begin
         load_and_swap(tbl[k].w);
         set_in_sum(tbl[k].s);
         sat_en = tbl[k].sat;
         set_act(tbl[k].a);
         act_valid_in = 1'b1;
         tick();
         act_valid_in = 1'b0;
         chk($sformatf("tbl%0d_sum", k), sum_col(0), tbl[k].exp);
         chk($sformatf("tbl%0d_vld", k), sum_valid[0], 1);
      end

      // swap with in-flight data: old weight 2, shadow 9
      load_and_swap(2);
      set_weights(9);
      w_load = 1'b1;
      tick();
      w_load = 1'b0;
      set_in_sum(0);
      sat_en = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         set_act(k);
         act_valid_in = 1'b1;
         tick();
      end
      act_valid_in = 1'b0;
      set_act(0);
      swap_req = 1'b1;
      seen = 0;
      done_cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 1) swap_req = 1'b0;
         if (sum_valid[COLS-1]) begin
            seen++;
            chk("drain_old_w", sum_col(COLS-1), 2*seen);
         end
         if (swap_done) done_cnt++;
         chk("drain_ready", act_ready, (i >= 1 && i <= 14) ? 0 : 1);
         chk("drain_done", swap_done, (i == 14) ? 1 : 0);
      end
      chk("drain_seen", seen, 4);
      chk("drain_done_cnt", done_cnt, 1);
      set_act(1);
      act_valid_in = 1'b1;
      tick();
      act_valid_in = 1'b0;
      chk("drain_new_w", sum_col(0), 9);
      repeat (COLS + 2) tick();

      // dropped valid during DRAIN, w_load during SWAP
      set_weights(6);
      w_load = 1'b1;
      tick();
      w_load = 1'b0;
      swap_req = 1'b1;
      tick();
      chk("err_ready_low", act_ready, 0);
      set_act(77);
      act_valid_in = 1'b1;
      tick();
      swap_req = 1'b0;
      act_valid_in = 1'b0;
      set_act(0);
      chk("err_set", err_drop, 1);
      chk("err_swap_done", swap_done, 1);
      set_weights(11);
      w_load = 1'b1;
      tick();
      w_load = 1'b0;
      chk("swapload_wb0", wb_col(0), 11);
      chk("swapload_wbN", wb_col(COLS-1), 11);
      chk("swapload_done_off", swap_done, 0);
      for (int i = 0; i < COLS + 2; i++) begin
         tick();
         chk("err_no_leak", act_valid_out, 0);
         chk("err_sticky", err_drop, 1);
         chk("err_ready", act_ready, 1);
      end
      set_in_sum(0);
      set_act(1);
      act_valid_in = 1'b1;
      tick();
      act_valid_in = 1'b0;
      chk("swapload_old_shadow", sum_col(0), 6);

      // asynchronous reset mid-drain with a full pipeline
      set_act(33);
      act_valid_in = 1'b1;
      repeat (COLS + 1) tick();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      act_valid_in = 1'b0;
      tick();
      chk("pre_rst_ready", act_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("rst_ready", act_ready, 1);
      chk("rst_err", err_drop, 0);
      chk("rst_right", active_right, 0);
      chk("rst_vout", act_valid_out, 0);
      chk("rst_sum_nz", |out_sum, 0);
      chk("rst_svld", sum_valid, 0);
      chk("rst_done", swap_done, 0);
      chk("rst_wb_nz", |out_weight_below, 0);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("post_rst_done", swap_done, 0);
         chk("post_rst_ready", act_ready, 1);
         chk("post_rst_vout", act_valid_out, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
